// File: rtl/exec_unit_gen2.sv
// exec_unit_gen2: register file, ALU with registered c/n/z flags, PC, IR and a
// circular hardware return-address stack; all state commits are gated by mem_rdy.

module exec_unit_gen2 #(
    parameter int DW        = 16,
    parameter int RAW       = 3,
    parameter int IMM_W     = 8,
    parameter int RAS_DEPTH = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [RAW-1:0] w_adr,
    input  logic [RAW-1:0] r_adr,
    input  logic [RAW-1:0] s_adr,
    input  logic [3:0]     alu_op,
    input  logic           s_sel,
    input  logic           reg_w_en,
    input  logic           ir_ld,
    input  logic           pc_ld,
    input  logic           pc_inc,
    input  logic [1:0]     pc_sel,
    input  logic           call,
    input  logic           adr_sel,
    input  logic [DW-1:0]  d_in,
    input  logic           mem_rdy,
    output logic [DW-1:0]  address,
    output logic [DW-1:0]  d_out,
    output logic [DW-1:0]  ir_out,
    output logic           c,
    output logic           n,
    output logic           z,
    output logic           ras_full,
    output logic           ras_empty,
    output logic           ras_err
);
    localparam int NREG = 2 ** RAW;
    localparam int PW   = $clog2(RAS_DEPTH);

    logic [DW-1:0]           rf_r [NREG];
    logic [DW-1:0]           pc_r;
    logic [DW-1:0]           ir_r;
    logic                    c_r;
    logic                    n_r;
    logic                    z_r;
    logic [DW-1:0]           ras_r [RAS_DEPTH];
    logic [PW-1:0]           ras_ptr_r;
    logic [PW:0]             ras_cnt_r;
    logic                    ras_err_r;

    logic                    en_s;
    logic [DW-1:0]           r_op_s;
    logic [DW-1:0]           s_op_s;
    logic [DW-1:0]           alu_res_s;
    logic                    alu_c_s;
    logic [DW:0]             ext_s;
    logic signed [IMM_W-1:0] imm_s;
    logic [DW-1:0]           branch_tgt_s;
    logic [DW-1:0]           pc_plus1_s;
    logic [DW-1:0]           pc_nxt_s;
    logic                    push_s;
    logic                    pop_s;
    logic [PW-1:0]           ras_top_idx_s;
    logic [DW-1:0]           ras_top_s;
    logic                    ras_empty_s;
    logic                    ras_full_s;
    logic                    ras_wr_s;
    logic [PW-1:0]           ras_wr_idx_s;
    logic [PW-1:0]           ras_ptr_nxt_s;
    logic [PW:0]             ras_cnt_nxt_s;
    logic                    ras_err_set_s;

    assign en_s          = mem_rdy;
    assign r_op_s        = rf_r[r_adr];
    assign s_op_s        = s_sel ? d_in : rf_r[s_adr];
    assign imm_s         = ir_r[IMM_W-1:0];
    assign branch_tgt_s  = pc_r + DW'(imm_s);
    assign pc_plus1_s    = pc_r + DW'(1'b1);
    assign push_s        = call & pc_ld;
    assign pop_s         = pc_ld & (pc_sel == 2'd2);
    // ras_ptr_r is the next free slot, so the top lives one below it.
    assign ras_top_idx_s = ras_ptr_r - PW'(1'b1);
    assign ras_top_s     = ras_r[ras_top_idx_s];
    assign ras_empty_s   = (ras_cnt_r == {(PW+1){1'b0}});
    assign ras_full_s    = (ras_cnt_r == (PW+1)'(RAS_DEPTH));

    assign address   = adr_sel ? r_op_s : pc_r;
    assign d_out     = alu_res_s;
    assign ir_out    = ir_r;
    assign c         = c_r;
    assign n         = n_r;
    assign z         = z_r;
    assign ras_full  = ras_full_s;
    assign ras_empty = ras_empty_s;
    assign ras_err   = ras_err_r;

    // ALU: result and carry/borrow/shifted-out bit for the selected operation.
    always_comb begin
        alu_res_s = s_op_s;
        alu_c_s   = 1'b0;
        ext_s     = {(DW+1){1'b0}};
        case (alu_op)
            4'h0: alu_res_s = s_op_s;
            4'h1: alu_res_s = r_op_s;
            4'h2: begin
                ext_s     = {1'b0, r_op_s} + {1'b0, s_op_s};
                alu_res_s = ext_s[DW-1:0];
                alu_c_s   = ext_s[DW];
            end
            4'h3: begin
                alu_res_s = r_op_s - s_op_s;
                alu_c_s   = (r_op_s < s_op_s);
            end
            4'h4: alu_res_s = r_op_s & s_op_s;
            4'h5: alu_res_s = r_op_s | s_op_s;
            4'h6: alu_res_s = r_op_s ^ s_op_s;
            4'h7: alu_res_s = ~s_op_s;
            4'h8: begin
                ext_s     = {1'b0, s_op_s} + (DW+1)'(1'b1);
                alu_res_s = ext_s[DW-1:0];
                alu_c_s   = ext_s[DW];
            end
            4'h9: begin
                alu_res_s = s_op_s - DW'(1'b1);
                alu_c_s   = (s_op_s == {DW{1'b0}});
            end
            4'hA: begin
                alu_res_s = {s_op_s[DW-2:0], 1'b0};
                alu_c_s   = s_op_s[DW-1];
            end
            4'hB: begin
                alu_res_s = {1'b0, s_op_s[DW-1:1]};
                alu_c_s   = s_op_s[0];
            end
            4'hC: begin
                alu_res_s = {s_op_s[DW-1], s_op_s[DW-1:1]};
                alu_c_s   = s_op_s[0];
            end
            default: alu_res_s = s_op_s;
        endcase
    end

    // Next PC: load has priority over increment; popping an empty stack holds.
    always_comb begin
        pc_nxt_s = pc_r;
        if (pc_ld) begin
            case (pc_sel)
                2'd0: pc_nxt_s = branch_tgt_s;
                2'd1: pc_nxt_s = alu_res_s;
                2'd2: begin
                    if (ras_empty_s) begin
                        pc_nxt_s = pc_r;
                    end else begin
                        pc_nxt_s = ras_top_s;
                    end
                end
                default: pc_nxt_s = pc_r;
            endcase
        end else if (pc_inc) begin
            pc_nxt_s = pc_plus1_s;
        end else begin
            pc_nxt_s = pc_r;
        end
    end

    // RAS control: push/pop/replace-top decisions and error detection.
    always_comb begin
        ras_wr_s      = 1'b0;
        ras_wr_idx_s  = ras_ptr_r;
        ras_ptr_nxt_s = ras_ptr_r;
        ras_cnt_nxt_s = ras_cnt_r;
        ras_err_set_s = 1'b0;
        if (push_s && pop_s) begin
            if (ras_empty_s) begin
                ras_wr_s      = 1'b1;
                ras_ptr_nxt_s = ras_ptr_r + PW'(1'b1);
                ras_cnt_nxt_s = (PW+1)'(1'b1);
                ras_err_set_s = 1'b1;
            end else begin
                ras_wr_s     = 1'b1;
                ras_wr_idx_s = ras_top_idx_s;
            end
        end else if (pop_s) begin
            if (ras_empty_s) begin
                ras_err_set_s = 1'b1;
            end else begin
                ras_ptr_nxt_s = ras_top_idx_s;
                ras_cnt_nxt_s = ras_cnt_r - (PW+1)'(1'b1);
            end
        end else if (push_s) begin
            // A full stack wraps onto its oldest entry, which sits at ras_ptr_r.
            ras_wr_s      = 1'b1;
            ras_ptr_nxt_s = ras_ptr_r + PW'(1'b1);
            if (ras_full_s) begin
                ras_err_set_s = 1'b1;
            end else begin
                ras_cnt_nxt_s = ras_cnt_r + (PW+1)'(1'b1);
            end
        end else begin
            ras_wr_s = 1'b0;
        end
    end

    // Register file: cleared by reset, written with the ALU result on commit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                rf_r[i] <= {DW{1'b0}};
            end
        end else if (en_s && reg_w_en) begin
            rf_r[w_adr] <= alu_res_s;
        end
    end

    // PC, IR and flags registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_r <= {DW{1'b0}};
            ir_r <= {DW{1'b0}};
            c_r  <= 1'b0;
            n_r  <= 1'b0;
            z_r  <= 1'b0;
        end else if (en_s) begin
            pc_r <= pc_nxt_s;
            if (ir_ld) begin
                ir_r <= d_in;
            end
            if (reg_w_en) begin
                c_r <= alu_c_s;
                n_r <= alu_res_s[DW-1];
                z_r <= (alu_res_s == {DW{1'b0}});
            end
        end
    end

    // Return-address stack storage, pointer, occupancy and sticky error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_r[i] <= {DW{1'b0}};
            end
            ras_ptr_r <= {PW{1'b0}};
            ras_cnt_r <= {(PW+1){1'b0}};
            ras_err_r <= 1'b0;
        end else if (en_s) begin
            if (ras_wr_s) begin
                ras_r[ras_wr_idx_s] <= pc_plus1_s;
            end
            ras_ptr_r <= ras_ptr_nxt_s;
            ras_cnt_r <= ras_cnt_nxt_s;
            ras_err_r <= ras_err_r | ras_err_set_s;
        end
    end

endmodule

// File: tb/tb_exec_unit_gen2.sv
// Bench for exec_unit_gen2: directed vector table, random stimulus against a
// queue-based reference model, and a wide-parameter instance check.

module tb_exec_unit_gen2;
    localparam int RAS_DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  w_adr, r_adr, s_adr;
    logic [3:0]  alu_op;
    logic        s_sel, reg_w_en, ir_ld, pc_ld, pc_inc, call, adr_sel, mem_rdy;
    logic [1:0]  pc_sel;
    logic [15:0] d_in, address, d_out, ir_out;
    logic        c, n, z, ras_full, ras_empty, ras_err;

    logic [3:0]  b_w_adr, b_r_adr, b_s_adr, b_alu_op;
    logic        b_s_sel, b_reg_w_en, b_ir_ld, b_pc_ld, b_pc_inc, b_call, b_adr_sel, b_mem_rdy;
    logic [1:0]  b_pc_sel;
    logic [31:0] b_d_in, b_address, b_d_out, b_ir_out;
    logic        b_c, b_n, b_z, b_ras_full, b_ras_empty, b_ras_err;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    exec_unit_gen2 dut (
        .clk(clk), .reset(reset), .w_adr(w_adr), .r_adr(r_adr), .s_adr(s_adr),
        .alu_op(alu_op), .s_sel(s_sel), .reg_w_en(reg_w_en), .ir_ld(ir_ld),
        .pc_ld(pc_ld), .pc_inc(pc_inc), .pc_sel(pc_sel), .call(call),
        .adr_sel(adr_sel), .d_in(d_in), .mem_rdy(mem_rdy), .address(address),
        .d_out(d_out), .ir_out(ir_out), .c(c), .n(n), .z(z),
        .ras_full(ras_full), .ras_empty(ras_empty), .ras_err(ras_err)
    );

    exec_unit_gen2 #(.DW(32), .RAW(4), .IMM_W(12), .RAS_DEPTH(4)) dut_w (
        .clk(clk), .reset(reset), .w_adr(b_w_adr), .r_adr(b_r_adr), .s_adr(b_s_adr),
        .alu_op(b_alu_op), .s_sel(b_s_sel), .reg_w_en(b_reg_w_en), .ir_ld(b_ir_ld),
        .pc_ld(b_pc_ld), .pc_inc(b_pc_inc), .pc_sel(b_pc_sel), .call(b_call),
        .adr_sel(b_adr_sel), .d_in(b_d_in), .mem_rdy(b_mem_rdy), .address(b_address),
        .d_out(b_d_out), .ir_out(b_ir_out), .c(b_c), .n(b_n), .z(b_z),
        .ras_full(b_ras_full), .ras_empty(b_ras_empty), .ras_err(b_ras_err)
    );

    typedef struct {
        logic [2:0]  w, r, s;
        logic [3:0]  op;
        logic        ssel, we, irld, pcld, pcinc;
        logic [1:0]  psel;
        logic        cl, rdy;
        logic [15:0] din;
        logic [15:0] e_dout, e_pc, e_ir;
        logic [2:0]  e_cnz, e_ras;
    } vec_t;

    vec_t tbl [30];

    // reference model state
    logic [15:0] m_rf [8];
    logic [15:0] m_pc, m_ir;
    logic        m_c, m_n, m_z, m_err;
    logic [15:0] m_ras [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] w, r, s, input logic [3:0] op,
                                input logic ssel, we, irld, pcld, pcinc,
                                input logic [1:0] psel, input logic cl, rdy,
                                input logic [15:0] din, e_dout, e_pc, e_ir,
                                input logic [2:0] e_cnz, e_ras);
        vec_t v;
        v.w = w; v.r = r; v.s = s; v.op = op; v.ssel = ssel; v.we = we;
        v.irld = irld; v.pcld = pcld; v.pcinc = pcinc; v.psel = psel;
        v.cl = cl; v.rdy = rdy; v.din = din; v.e_dout = e_dout;
        v.e_pc = e_pc; v.e_ir = e_ir; v.e_cnz = e_cnz; v.e_ras = e_ras;
        return v;
    endfunction

    task automatic idle();
        w_adr = 3'd0; r_adr = 3'd0; s_adr = 3'd0; alu_op = 4'd0; s_sel = 1'b0;
        reg_w_en = 1'b0; ir_ld = 1'b0; pc_ld = 1'b0; pc_inc = 1'b0; pc_sel = 2'd0;
        call = 1'b0; adr_sel = 1'b0; d_in = 16'd0; mem_rdy = 1'b1;
        b_w_adr = 4'd0; b_r_adr = 4'd0; b_s_adr = 4'd0; b_alu_op = 4'd0; b_s_sel = 1'b0;
        b_reg_w_en = 1'b0; b_ir_ld = 1'b0; b_pc_ld = 1'b0; b_pc_inc = 1'b0; b_pc_sel = 2'd0;
        b_call = 1'b0; b_adr_sel = 1'b0; b_d_in = 32'd0; b_mem_rdy = 1'b1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_rf[i] = 16'd0;
        m_pc = 16'd0; m_ir = 16'd0; m_c = 1'b0; m_n = 1'b0; m_z = 1'b0; m_err = 1'b0;
        m_ras.delete();
    endtask

    // ALU expressed as plain arithmetic on 32-bit integers.
    task automatic model_alu(input logic [3:0] op, input logic [15:0] r, s,
                             output logic [15:0] res, output logic cy);
        int unsigned t;
        res = s; cy = 1'b0; t = 0;
        case (op)
            4'd1:  res = r;
            4'd2:  begin t = r + s; res = t[15:0]; cy = t[16]; end
            4'd3:  begin res = r - s; cy = (r < s); end
            4'd4:  res = r & s;
            4'd5:  res = r | s;
            4'd6:  res = r ^ s;
            4'd7:  res = ~s;
            4'd8:  begin t = s + 1; res = t[15:0]; cy = t[16]; end
            4'd9:  begin res = s - 16'd1; cy = (s == 16'd0); end
            4'd10: begin t = s * 2; res = t[15:0]; cy = t[16]; end
            4'd11: begin res = s / 16'd2; cy = ((s % 16'd2) == 16'd1); end
            4'd12: begin res = (s / 16'd2) | (s & 16'h8000); cy = ((s % 16'd2) == 16'd1); end
            default: res = s;
        endcase
    endtask

    task automatic model_commit(input logic [15:0] res, input logic cy);
        logic [15:0] p1;
        int off;
        logic push, pop;
        p1 = m_pc + 16'd1;
        push = call && pc_ld;
        pop = pc_ld && (pc_sel == 2'd2);
        if (pc_ld) begin
            case (pc_sel)
                2'd0: begin
                    off = int'(m_ir[7:0]);
                    if (off > 127) off = off - 256;
                    m_pc = 16'(int'(m_pc) + off);
                end
                2'd1: m_pc = res;
                2'd2: begin
                    if (m_ras.size() > 0) m_pc = m_ras[m_ras.size()-1];
                    else m_err = 1'b1;
                end
                default: m_pc = m_pc;
            endcase
        end else if (pc_inc) begin
            m_pc = p1;
        end
        if (push && pop) begin
            if (m_ras.size() == 0) m_ras.push_back(p1);
            else m_ras[m_ras.size()-1] = p1;
        end else if (pop) begin
            if (m_ras.size() > 0) void'(m_ras.pop_back());
        end else if (push) begin
            m_ras.push_back(p1);
            if (m_ras.size() > RAS_DEPTH) begin
                void'(m_ras.pop_front());
                m_err = 1'b1;
            end
        end
        if (reg_w_en) begin
            m_rf[w_adr] = res; m_c = cy; m_n = res[15]; m_z = (res == 16'd0);
        end
        if (ir_ld) m_ir = d_in;
    endtask

    initial begin
        logic [15:0] mres, mr, ms;
        logic mcy;
        logic [2:0] exp_ras;

        //        w    r    s    op   ss   we   ir   ld   inc  sel  cl   rdy  din       dout      pc        ir        cnz     ras
        tbl[0]  = mk(3'd1,3'd0,3'd0,4'd0,1'b1,1'b1,1'b0,1'b0,1'b0,2'd0,1'b0,1'b1,16'h7FFF,16'h7FFF,16'h0000,16'h0000,3'b000,3'b010);
        tbl[1]  = mk(3'd2,3'd0,3'd0,4'd0,1'b1,1'b1,1'b0,1'b0,1'b0,2'd0,1'b0,1'b1,16'h0001,16'h0001,16'h0000,16'h0000,3'b000,3'b010);
        tbl[2]  = mk(3'd3,3'd1,3'd2,4'd2,1'b0,1'b1,1'b0,1'b0,1'b0,2'd0,1'b0,1'b1,16'h0000,16'h8000,16'h0000,16'h0000,3'b010,3'b010);
        tbl[3]  = mk(3'd4,3'd2,3'd1,4'd3,1'b0,1'b1,1'b0,1'b0,1'b0,2'd0,1'b0,1'b1,16'h0000,16'h8002,16'h0000,16'h0000,3'b110,3'b010);
        tbl[4]  = mk(3'd5,3'd0,3'd0,4'd0,1'b1,1'b1,1'b1,1'b0,1'b1,2'd0,1'b0,1'b0,16'h1234,16'h1234,16'h0000,16'h0000,3'b110,3'b010);
        tbl[5]  = tbl[4];
        tbl[6]  = tbl[4];
        tbl[7]  = mk(3'd6,3'd0,3'd0,4'd0,1'b1,1'b1,1'b1,1'b0,1'b1,2'd0,1'b0,1'b1,16'h00FE,16'h00FE,16'h0001,16'h00FE,3'b000,3'b010);
        tbl[8]  = mk(3'd0,3'd5,3'd0,4'd1,1'b0,1'b0,1'b0,1'b0,1'b1,2'd0,1'b0,1'b1,16'h0000,16'h0000,16'h0002,16'h00FE,3'b000,3'b010);
        tbl[9]  = mk(3'd0,3'd0,3'd0,4'd0,1'b1,1'b0,1'b0,1'b1,1'b0,2'd1,1'b0,1'b1,16'h0010,16'h0010,16'h0010,16'h00FE,3'b000,3'b010);
        tbl[10] = mk(3'd0,3'd0,3'd0,4'd0,1'b0,1'b0,1'b0,1'b1,1'b0,2'd0,1'b0,1'b1,16'h0000,16'h0000,16'h000E,16'h00FE,3'b000,3'b010);
        tbl[11] = mk(3'd0,3'd0,3'd0,4'd0,1'b1,1'b0,1'b0,1'b1,1'b0,2'd1,1'b0,1'b1,16'hFFFF,16'hFFFF,16'hFFFF,16'h00FE,3'b000,3'b010);
        tbl[12] = mk(3'd0,3'd0,3'd0,4'd0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd0,1'b0,1'b1,16'h0000,16'h0000,16'h0000,16'h00FE,3'b000,3'b010);
        tbl[13] = mk(3'd0,3'd0,3'd0,4'd0,1'b1,1'b0,1'b0,1'b1,1'b0,2'd1,1'b0,1'b1,16'h0020,16'h0020,16'h0020,16'h00FE,3'b000,3'b010);
        tbl[14] = mk(3'd0,3'd0,3'd0,4'd0,1'b1,1'b0,1'b0,1'b1,1'b0,2'd1,1'b1,1'b1,16'h0100,16'h0100,16'h0100,16'h00FE,3'b000,3'b000);
        tbl[15] = mk(3'd0,3'd0,3'd0,4'd0,1'b0,1'b0,1'b0,1'b1,1'b0,2'd2,1'b0,1'b1,16'h0000,16'h0000,16'h0021,16'h00FE,3'b000,3'b010);
        tbl[16] = mk(3'd0,3'd0,3'd0,4'd0,1'b1,1'b0,1'b0,1'b1,1'b0,2'd1,1'b1,1'b1,16'h0100,16'h0100,16'h0100,16'h00FE,3'b000,3'b000);
        tbl[17] = mk(3'd0,3'd0,3'd0,4'd0,1'b1,1'b0,1'b0,1'b1,1'b0,2'd1,1'b1,1'b1,16'h0200,16'h0200,16'h0200,16'h00FE,3'b000,3'b000);
        tbl[18] = mk(3'd0,3'd0,3'd0,4'd0,1'b1,1'b0,1'b0,1'b1,1'b0,2'd1,1'b1,1'b1,16'h0300,16'h0300,16'h0300,16'h00FE,3'b000,3'b000);
        tbl[19] = mk(3'd0,3'd0,3'd0,4'd0,1'b1,1'b0,1'b0,1'b1,1'b0,2'd1,1'b1,1'b1,16'h0400,16'h0400,16'h0400,16'h00FE,3'b000,3'b100);
        tbl[20] = mk(3'd0,3'd0,3'd0,4'd0,1'b1,1'b0,1'b0,1'b1,1'b0,2'd1,1'b1,1'b1,16'h0500,16'h0500,16'h0500,16'h00FE,3'b000,3'b101);
        tbl[21] = mk(3'd0,3'd0,3'd0,4'd0,1'b0,1'b0,1'b0,1'b1,1'b0,2'd2,1'b0,1'b1,16'h0000,16'h0000,16'h0401,16'h00FE,3'b000,3'b001);
        tbl[22] = mk(3'd0,3'd0,3'd0,4'd0,1'b0,1'b0,1'b0,1'b1,1'b0,2'd2,1'b0,1'b1,16'h0000,16'h0000,16'h0301,16'h00FE,3'b000,3'b001);
        tbl[23] = mk(3'd0,3'd0,3'd0,4'd0,1'b0,1'b0,1'b0,1'b1,1'b0,2'd2,1'b0,1'b1,16'h0000,16'h0000,16'h0201,16'h00FE,3'b000,3'b001);
        tbl[24] = mk(3'd0,3'd0,3'd0,4'd0,1'b0,1'b0,1'b0,1'b1,1'b0,2'd2,1'b0,1'b1,16'h0000,16'h0000,16'h0101,16'h00FE,3'b000,3'b011);
        tbl[25] = mk(3'd0,3'd0,3'd0,4'd0,1'b0,1'b0,1'b0,1'b1,1'b0,2'd2,1'b0,1'b1,16'h0000,16'h0000,16'h0101,16'h00FE,3'b000,3'b011);
        tbl[26] = mk(3'd0,3'd0,3'd0,4'd0,1'b1,1'b0,1'b0,1'b1,1'b1,2'd1,1'b0,1'b1,16'h0040,16'h0040,16'h0040,16'h00FE,3'b000,3'b011);
        tbl[27] = mk(3'd0,3'd0,3'd0,4'd0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd1,1'b1,1'b1,16'h0000,16'h0000,16'h0041,16'h00FE,3'b000,3'b011);
        tbl[28] = mk(3'd7,3'd0,3'd0,4'd9,1'b1,1'b1,1'b0,1'b0,1'b0,2'd0,1'b0,1'b1,16'h0000,16'hFFFF,16'h0041,16'h00FE,3'b110,3'b011);
        tbl[29] = mk(3'd7,3'd0,3'd0,4'd12,1'b1,1'b1,1'b0,1'b0,1'b0,2'd0,1'b0,1'b1,16'h8001,16'hC000,16'h0041,16'h00FE,3'b110,3'b011);

        idle();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset dout", d_out, 16'h0000);
        chk("reset addr", address, 16'h0000);
        chk("reset ir", ir_out, 16'h0000);
        chk("reset cnz", {c, n, z}, 3'b000);
        chk("reset ras", {ras_full, ras_empty, ras_err}, 3'b010);
        reset = 1'b0;

        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            w_adr = tbl[i].w; r_adr = tbl[i].r; s_adr = tbl[i].s; alu_op = tbl[i].op;
            s_sel = tbl[i].ssel; reg_w_en = tbl[i].we; ir_ld = tbl[i].irld;
            pc_ld = tbl[i].pcld; pc_inc = tbl[i].pcinc; pc_sel = tbl[i].psel;
            call = tbl[i].cl; mem_rdy = tbl[i].rdy; d_in = tbl[i].din; adr_sel = 1'b0;
            #1;
            chk($sformatf("v%0d dout", i), d_out, tbl[i].e_dout);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d pc", i), address, tbl[i].e_pc);
            chk($sformatf("v%0d ir", i), ir_out, tbl[i].e_ir);
            chk($sformatf("v%0d cnz", i), {c, n, z}, tbl[i].e_cnz);
            chk($sformatf("v%0d ras", i), {ras_full, ras_empty, ras_err}, tbl[i].e_ras);
        end

        // reset asserted while stalled takes effect without a clock edge
        @(negedge clk);
        idle();
        mem_rdy = 1'b0; pc_inc = 1'b1; adr_sel = 1'b1; r_adr = 3'd4;
        #1;
        chk("pre-reset r4", address, 16'h8002);
        reset = 1'b1;
        #1;
        chk("midstall addr", address, 16'h0000);
        chk("midstall ir", ir_out, 16'h0000);
        chk("midstall cnz", {c, n, z}, 3'b000);
        chk("midstall ras", {ras_full, ras_empty, ras_err}, 3'b010);
        @(negedge clk);
        reset = 1'b0;
        model_reset();

        for (int k = 0; k < 4000; k++) begin
            @(negedge clk);
            if ($urandom_range(0, 149) == 0) begin
                idle();
                reset = 1'b1;
                model_reset();
                #1;
                chk("rnd reset ir", ir_out, 16'h0000);
                chk("rnd reset ras", {ras_full, ras_empty, ras_err}, 3'b010);
                @(negedge clk);
                reset = 1'b0;
            end
            w_adr = 3'($urandom_range(0, 7)); r_adr = 3'($urandom_range(0, 7));
            s_adr = 3'($urandom_range(0, 7)); alu_op = 4'($urandom_range(0, 15));
            s_sel = 1'($urandom_range(0, 1)); reg_w_en = 1'($urandom_range(0, 1));
            ir_ld = 1'($urandom_range(0, 1)); pc_ld = ($urandom_range(0, 3) == 0);
            pc_inc = 1'($urandom_range(0, 1)); pc_sel = 2'($urandom_range(0, 3));
            call = ($urandom_range(0, 2) == 0); adr_sel = 1'($urandom_range(0, 1));
            d_in = 16'($urandom); mem_rdy = ($urandom_range(0, 3) != 0);
            #1;
            mr = m_rf[r_adr];
            ms = s_sel ? d_in : m_rf[s_adr];
            model_alu(alu_op, mr, ms, mres, mcy);
            chk("rnd dout", d_out, mres);
            chk("rnd addr", address, adr_sel ? mr : m_pc);
            @(posedge clk);
            if (mem_rdy) model_commit(mres, mcy);
            #1;
            exp_ras = {(m_ras.size() == RAS_DEPTH), (m_ras.size() == 0), m_err};
            chk("rnd ir", ir_out, m_ir);
            chk("rnd cnz", {c, n, z}, {m_c, m_n, m_z});
            chk("rnd ras", {ras_full, ras_empty, ras_err}, exp_ras);
        end

        // wide instance: DW=32, RAW=4, IMM_W=12
        @(negedge clk);
        idle();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        b_w_adr = 4'd15; b_s_sel = 1'b1; b_reg_w_en = 1'b1; b_d_in = 32'hDEADBEEF;
        @(negedge clk);
        b_reg_w_en = 1'b0; b_ir_ld = 1'b1; b_d_in = 32'h00000FF0;
        @(negedge clk);
        b_ir_ld = 1'b0; b_pc_ld = 1'b1; b_pc_sel = 2'd1; b_d_in = 32'h00000100;
        @(negedge clk);
        chk("w pc load", b_address, 32'h00000100);
        b_pc_sel = 2'd0; b_s_sel = 1'b0;
        @(negedge clk);
        chk("w branch12", b_address, 32'h000000F0);
        chk("w ir", b_ir_out, 32'h00000FF0);
        b_pc_ld = 1'b0; b_mem_rdy = 1'b0; b_pc_inc = 1'b1;
        b_adr_sel = 1'b1; b_r_adr = 4'd15; b_alu_op = 4'd1;
        #1;
        chk("w addr r15", b_address, 32'hDEADBEEF);
        chk("w dout r15", b_d_out, 32'hDEADBEEF);
        @(negedge clk);
        b_adr_sel = 1'b0;
        #1;
        chk("w stall pc", b_address, 32'h000000F0);
        b_adr_sel = 1'b1;
        reset = 1'b1;
        #1;
        chk("w midstall r15", b_address, 32'h00000000);
        chk("w midstall ir", b_ir_out, 32'h00000000);
        chk("w midstall flags", {b_c, b_n, b_z, b_ras_full, b_ras_empty, b_ras_err}, 6'b000010);
        @(negedge clk);
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
